reg_file_rd: RTL and testbench
==============================

# reg_file_rd

Register file for the CPU datapath: sixteen 16-bit registers, one write port and two registered read ports. It is the read-side counterpart of the single `reg16` storage element. The decode stage issues a read of two source operands, and the write-back stage writes one result per cycle. Register 0 is hard-wired to zero.

## Interface
Parameters:
- `WIDTH`, 16: data width of every register and port.
- `ADDR_BITS`, 4: address width; the register count is 2^ADDR_BITS.

Ports:
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `Write`, in, 1: write enable, sampled at the rising edge of `CLK`.
- `WAddr`, in, ADDR_BITS: destination register of the write.
- `I`, in, WIDTH: write data.
- `Read`, in, 1: read request, sampled at the rising edge of `CLK`.
- `RAddrA`, in, ADDR_BITS: source register for port A.
- `RAddrB`, in, ADDR_BITS: source register for port B.
- `OA`, out, WIDTH: registered read data, port A.
- `OB`, out, WIDTH: registered read data, port B.
- `Valid`, out, 1: one-cycle pulse marking fresh `OA`/`OB`.

## Operation
- Write:
  - At an edge with `Write=1` and `WAddr!=0`, the register at `WAddr` loads `I`.
  - `Write=1` with `WAddr=0` is silently discarded.
- Read:
  - At an edge with `Read=1`, `OA` is loaded with `reg[RAddrA]` and `OB` with `reg[RAddrB]`.
  - `Valid` is loaded with 1.
- Read with `Read=0`:
  - `OA` and `OB` hold their last value.
  - `Valid` is loaded with 0.
- Register 0 always reads 0x0000 on both ports.
- `RAddrA` and `RAddrB` may be equal; both ports then return the same value.
- Write and read of the same register at the same edge: see Configuration.
- Reset:
  - At an edge with `Reset=1`, all registers, `OA`, and `OB` are set to 0, and `Valid` is set to 0.
  - Reset overrides `Write` and `Read` at the same edge.
  - Reset asserted mid-sequence discards any pending read result. `Valid` is 0 in the cycle after reset.
- No arithmetic is performed. Addresses are unsigned and every value in range is valid.

## Timing
- Write latency: 1 edge. Data written at edge N can be read by a `Read` sampled at edge N+1, returning the new value.
- Read latency: 1 edge. `Read` sampled at edge N drives `OA`/`OB`/`Valid` after edge N and holds them until edge N+1.
- Back-to-back reads are allowed every cycle. With `Read` held high, `Valid` stays high continuously.
- No back-pressure: the consumer must take `OA`/`OB` in the cycle `Valid=1`. The values nevertheless persist until the next read or reset.
- Output reset values: `OA`=0x0000, `OB`=0x0000, `Valid`=0.

## Configuration
- `REGFILE_BYPASS_EN` defined (write-first forwarding):
  - When `Write=1`, `Read=1`, and `WAddr==RAddrA` (and `WAddr!=0`) at the same edge, `OA` gets `I`.
  - `OB` follows the same rule with `RAddrB`.
- `REGFILE_BYPASS_EN` undefined (read-first):
  - In the same collision, the port returns the register's old value.
- In both builds the register itself is updated identically.
- Writes to register 0 are never forwarded.

## Structure
- Shared package `reg_file_pkg` holds:
  - `WIDTH` and `ADDR_BITS` defaults;
  - `NUM_REGS` = 2^ADDR_BITS;
  - `ZERO_REG` = 0;
  - typedefs `reg_data_t` (WIDTH bits) and `reg_addr_t` (ADDR_BITS bits).
- Sub-module `reg_file_rd_port` is instantiated twice, once for port A and once for port B. It contains:
  - the address mux;
  - the zero-register override;
  - the bypass compare (under the macro);
  - the output register.
- The top level holds the storage array, the write decode, and the `Valid` flop.

## Test plan
- Reset check: assert `Reset` for 2 cycles with `Write=1`, `WAddr=3`, `I=0xFFFF` → `OA`=`OB`=0, `Valid`=0. A subsequent read of reg 3 returns 0x0000.
- Write then read: write 0x1234 to reg 5, then 0xBEEF to reg 9. Next cycle, read A=5, B=9 → one cycle later `OA`=0x1234, `OB`=0xBEEF, `Valid`=1 for exactly that cycle.
- Zero register: write 0xAAAA to reg 0, then read A=0, B=0 → `OA`=`OB`=0x0000.
- Collision: reg 7 holds 0x0001. At the same edge, write 0x0002 to reg 7 and read A=7, B=7:
  - With `REGFILE_BYPASS_EN`: `OA`=`OB`=0x0002.
  - Without it: `OA`=`OB`=0x0001.
  - In both builds, the next read of reg 7 returns 0x0002.
- Incrementing sweep: for k=1..15, write k to reg k, then read A=k, B=k-1 each cycle:
  - `OA`=k;
  - `OB`=k-1, except `OB`=0 when k=1 (reg 0);
  - `Valid` stays high across the back-to-back reads.
- Hold and mid-read reset: read reg 5 (0x1234), then drop `Read` for 3 cycles → `OA` holds 0x1234 and `Valid`=0. Issue a read and assert `Reset` at the same edge → `Valid`=0 and `OA`=0 next cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 16x16 register file.
// Imported by reg_file_rd and reg_file_rd_port.
package reg_file_pkg;

    localparam int WIDTH     = 16;
    localparam int ADDR_BITS = 4;
    localparam int NUM_REGS  = 1 << ADDR_BITS;
    localparam int ZERO_REG  = 0;

    typedef logic [WIDTH-1:0]     reg_data_t;
    typedef logic [ADDR_BITS-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: address mux, zero override, output flop.
// Write-first forwarding is compiled in when REGFILE_BYPASS_EN is defined.
import reg_file_pkg::*;

module reg_file_rd_port #(
    parameter int WIDTH     = reg_file_pkg::WIDTH,
    parameter int ADDR_BITS = reg_file_pkg::ADDR_BITS,
    parameter int NREGS     = 1 << ADDR_BITS
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_read,
    input  logic [ADDR_BITS-1:0]             i_addr,
    input  logic [NREGS-1:0][WIDTH-1:0]      i_regs,
`ifdef REGFILE_BYPASS_EN
    input  logic                             i_write,
    input  logic [ADDR_BITS-1:0]             i_waddr,
    input  logic [WIDTH-1:0]                 i_wdata,
`endif
    output logic [WIDTH-1:0]                 o_data
);

    localparam logic [ADDR_BITS-1:0] ZADDR = ADDR_BITS'(ZERO_REG);

    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_data;

    always_comb begin
        w_rdata = i_regs[i_addr];
        if (i_addr == ZADDR) begin
            w_rdata = '0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_hit;

    // Forward the in-flight write; writes to r0 are dropped, so never hit.
    always_comb begin
        w_hit  = i_write && (i_waddr == i_addr) && (i_waddr != ZADDR);
        w_next = w_hit ? i_wdata : w_rdata;
    end
`else
    always_comb begin
        w_next = w_rdata;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data <= '0;
        end else if (i_read) begin
            r_data <= w_next;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/reg_file_rd.sv
// 16x16 register file, one write port, two registered read ports, r0 = 0.
// Define REGFILE_BYPASS_EN for write-first forwarding on read/write collisions.
import reg_file_pkg::*;

module reg_file_rd #(
    parameter int WIDTH     = reg_file_pkg::WIDTH,
    parameter int ADDR_BITS = reg_file_pkg::ADDR_BITS
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 Write,
    input  logic [ADDR_BITS-1:0] WAddr,
    input  logic [WIDTH-1:0]     I,
    input  logic                 Read,
    input  logic [ADDR_BITS-1:0] RAddrA,
    input  logic [ADDR_BITS-1:0] RAddrB,
    output logic [WIDTH-1:0]     OA,
    output logic [WIDTH-1:0]     OB,
    output logic                 Valid
);

    localparam int NREGS = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ZADDR = ADDR_BITS'(ZERO_REG);

    logic [NREGS-1:0][WIDTH-1:0] r_regs;
    logic                        r_valid;
    logic                        w_wen;

    assign w_wen = Write && (WAddr != ZADDR);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_regs <= '0;
        end else if (w_wen) begin
            r_regs[WAddr] <= I;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= Read;
        end
    end

    assign Valid = r_valid;

    reg_file_rd_port #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS),
        .NREGS     (NREGS)
    ) u_port_a (
        .i_clk   (CLK),
        .i_reset (Reset),
        .i_read  (Read),
        .i_addr  (RAddrA),
        .i_regs  (r_regs),
`ifdef REGFILE_BYPASS_EN
        .i_write (Write),
        .i_waddr (WAddr),
        .i_wdata (I),
`endif
        .o_data  (OA)
    );

    reg_file_rd_port #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS),
        .NREGS     (NREGS)
    ) u_port_b (
        .i_clk   (CLK),
        .i_reset (Reset),
        .i_read  (Read),
        .i_addr  (RAddrB),
        .i_regs  (r_regs),
`ifdef REGFILE_BYPASS_EN
        .i_write (Write),
        .i_waddr (WAddr),
        .i_wdata (I),
`endif
        .o_data  (OB)
    );

endmodule

// File: tb/tb_reg_file_rd.sv
// Directed self-checking bench for reg_file_rd.
// Collision expectations follow REGFILE_BYPASS_EN.
module tb_reg_file_rd;

    logic        CLK;
    logic        Reset;
    logic        Write;
    logic [3:0]  WAddr;
    logic [15:0] I;
    logic        Read;
    logic [3:0]  RAddrA;
    logic [3:0]  RAddrB;
    logic [15:0] OA;
    logic [15:0] OB;
    logic        Valid;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_rd dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .Write  (Write),
        .WAddr  (WAddr),
        .I      (I),
        .Read   (Read),
        .RAddrA (RAddrA),
        .RAddrB (RAddrB),
        .OA     (OA),
        .OB     (OB),
        .Valid  (Valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        Write  = 1'b0;
        Read   = 1'b0;
        WAddr  = 4'd0;
        I      = 16'h0000;
        RAddrA = 4'd0;
        RAddrB = 4'd0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Write = 1'b1;
        WAddr = 4'd3;
        I     = 16'hFFFF;
        Read  = 1'b1;
        RAddrA = 4'd3;
        RAddrB = 4'd3;
        step();
        step();
        n_checks++;
        if (OA !== 16'h0000) begin
            $display("FAIL reset_OA got %h want 0000", OA);
            n_fail++;
        end
        n_checks++;
        if (OB !== 16'h0000) begin
            $display("FAIL reset_OB got %h want 0000", OB);
            n_fail++;
        end
        n_checks++;
        if (Valid !== 1'b0) begin
            $display("FAIL reset_Valid got %b want 0", Valid);
            n_fail++;
        end
        Reset = 1'b0;
        idle();
        Read   = 1'b1;
        RAddrA = 4'd3;
        RAddrB = 4'd3;
        step();
        n_checks++;
        if (OA !== 16'h0000 || OB !== 16'h0000 || Valid !== 1'b1) begin
            $display("FAIL reset_read_r3 got OA=%h OB=%h V=%b want 0000 0000 1",
                     OA, OB, Valid);
            n_fail++;
        end
        idle();
    endtask

    task automatic test_write_read();
        idle();
        Write = 1'b1;
        WAddr = 4'd5;
        I     = 16'h1234;
        step();
        WAddr = 4'd9;
        I     = 16'hBEEF;
        step();
        idle();
        Read   = 1'b1;
        RAddrA = 4'd5;
        RAddrB = 4'd9;
        step();
        n_checks++;
        if (OA !== 16'h1234 || OB !== 16'hBEEF || Valid !== 1'b1) begin
            $display("FAIL write_read got OA=%h OB=%h V=%b want 1234 beef 1",
                     OA, OB, Valid);
            n_fail++;
        end
        idle();
        step();
        n_checks++;
        if (Valid !== 1'b0 || OA !== 16'h1234 || OB !== 16'hBEEF) begin
            $display("FAIL valid_pulse got OA=%h OB=%h V=%b want 1234 beef 0",
                     OA, OB, Valid);
            n_fail++;
        end
    endtask

    task automatic test_zero_reg();
        idle();
        Write = 1'b1;
        WAddr = 4'd0;
        I     = 16'hAAAA;
        step();
        idle();
        Read = 1'b1;
        step();
        n_checks++;
        if (OA !== 16'h0000 || OB !== 16'h0000) begin
            $display("FAIL zero_reg got OA=%h OB=%h want 0000 0000", OA, OB);
            n_fail++;
        end
        // Same-edge write to r0 must never be forwarded.
        Write  = 1'b1;
        WAddr  = 4'd0;
        I      = 16'h5555;
        RAddrA = 4'd0;
        RAddrB = 4'd9;
        step();
        n_checks++;
        if (OA !== 16'h0000 || OB !== 16'hBEEF) begin
            $display("FAIL zero_collide got OA=%h OB=%h want 0000 beef", OA, OB);
            n_fail++;
        end
        idle();
    endtask

    task automatic test_collision();
        logic [15:0] exp;
`ifdef REGFILE_BYPASS_EN
        exp = 16'h0002;
`else
        exp = 16'h0001;
`endif
        idle();
        Write = 1'b1;
        WAddr = 4'd7;
        I     = 16'h0001;
        step();
        I      = 16'h0002;
        Read   = 1'b1;
        RAddrA = 4'd7;
        RAddrB = 4'd7;
        step();
        n_checks++;
        if (OA !== exp || OB !== exp) begin
            $display("FAIL collision got OA=%h OB=%h want %h", OA, OB, exp);
            n_fail++;
        end
        Write = 1'b0;
        step();
        n_checks++;
        if (OA !== 16'h0002 || OB !== 16'h0002) begin
            $display("FAIL collision_after got OA=%h OB=%h want 0002", OA, OB);
            n_fail++;
        end
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        for (int j = 1; j <= 16; j++) begin
            Write  = (j <= 15);
            WAddr  = 4'(j);
            I      = 16'(j);
            Read   = (j >= 2);
            RAddrA = 4'(j - 1);
            RAddrB = 4'(j - 2);
            step();
            if (j >= 2) begin
                n_checks++;
                if (OA !== 16'(j - 1) || OB !== 16'(j - 2) || Valid !== 1'b1) begin
                    $display("FAIL sweep k=%0d got OA=%h OB=%h V=%b want %h %h 1",
                             j - 1, OA, OB, Valid, 16'(j - 1), 16'(j - 2));
                    n_fail++;
                end
            end
        end
        idle();
    endtask

    task automatic test_hold_reset();
        idle();
        Write = 1'b1;
        WAddr = 4'd5;
        I     = 16'h1234;
        step();
        idle();
        Read   = 1'b1;
        RAddrA = 4'd5;
        RAddrB = 4'd15;
        step();
        n_checks++;
        if (OA !== 16'h1234 || OB !== 16'h000F) begin
            $display("FAIL hold_read got OA=%h OB=%h want 1234 000f", OA, OB);
            n_fail++;
        end
        Read   = 1'b0;
        RAddrA = 4'd1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (OA !== 16'h1234 || Valid !== 1'b0) begin
                $display("FAIL hold c=%0d got OA=%h V=%b want 1234 0", c, OA, Valid);
                n_fail++;
            end
        end
        Read   = 1'b1;
        RAddrA = 4'd5;
        Reset  = 1'b1;
        step();
        n_checks++;
        if (OA !== 16'h0000 || OB !== 16'h0000 || Valid !== 1'b0) begin
            $display("FAIL mid_reset got OA=%h OB=%h V=%b want 0000 0000 0",
                     OA, OB, Valid);
            n_fail++;
        end
        Reset = 1'b0;
        step();
        n_checks++;
        if (OA !== 16'h0000 || Valid !== 1'b1) begin
            $display("FAIL post_reset_r5 got OA=%h V=%b want 0000 1", OA, Valid);
            n_fail++;
        end
        idle();
    endtask

    initial begin
        Reset = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_collision();
        test_back_to_back();
        test_hold_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
